// File: rtl/cpu_bus_master.sv
// NES CPU bus initiator: turns valid/ready requests into M2-timed bus cycles,
// free-running dummy reads in between so M2 stays continuous.
module cpu_bus_master #(
  parameter int          PH_LO     = 6,
  parameter int          PH_HI     = 6,
  parameter logic [15:0] IDLE_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdat,
  output logic        done,
  output logic [7:0]  rd_data,
  output logic        m2,
  output logic [15:0] cpu_addr,
  output logic        cpu_rw,
  output logic [7:0]  cpu_dout,
  output logic        cpu_doe,
  input  logic [7:0]  cpu_din
);

  localparam int PH_MAX = (PH_LO > PH_HI) ? PH_LO : PH_HI;
  localparam int CW     = $clog2(PH_MAX);

  typedef enum logic [1:0] {
    ST_STOP,
    ST_LO,
    ST_HI
  } state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        pend_q, pend_d;
  logic        slot_we_q, slot_we_d;
  logic [15:0] slot_addr_q, slot_addr_d;
  logic [7:0]  slot_wdat_q, slot_wdat_d;

  logic        req_cyc_q, req_cyc_d;
  logic [15:0] addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [7:0]  dout_q, dout_d;
  logic        doe_q, doe_d;
  logic        done_q, done_d;
  logic [7:0]  rdat_q, rdat_d;

  logic lo_end, hi_end, cyc_start, to_stop, acc;

  assign lo_end = (state_q == ST_LO) && (cnt_q == CW'(PH_LO - 1));
  assign hi_end = (state_q == ST_HI) && (cnt_q == CW'(PH_HI - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_STOP: begin
        if (run) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end
      end
      ST_LO: begin
        if (lo_end) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HI: begin
        if (hi_end) begin
          state_d = run ? ST_LO : ST_STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_STOP;
        cnt_d   = '0;
      end
    endcase
  end

  assign cyc_start = (state_d == ST_LO) && (state_q != ST_LO);
  assign to_stop   = (state_d == ST_STOP) && (state_q != ST_STOP);
  assign acc       = req_valid && !pend_q;

  always_comb begin
    pend_d      = pend_q;
    slot_we_d   = slot_we_q;
    slot_addr_d = slot_addr_q;
    slot_wdat_d = slot_wdat_q;
    req_cyc_d   = req_cyc_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    dout_d      = dout_q;
    rdat_d      = rdat_q;

    if (acc) begin
      pend_d      = 1'b1;
      slot_we_d   = req_we;
      slot_addr_d = req_addr;
      slot_wdat_d = req_wdat;
    end

    // The cycle type is fixed on the edge into the first LO clk.
    if (cyc_start) begin
      if (pend_q) begin
        pend_d    = 1'b0;
        req_cyc_d = 1'b1;
        addr_d    = slot_addr_q;
        rw_d      = !slot_we_q;
        dout_d    = slot_wdat_q;
      end else begin
        req_cyc_d = 1'b0;
        addr_d    = IDLE_ADDR;
        rw_d      = 1'b1;
      end
    end else if (to_stop) begin
      req_cyc_d = 1'b0;
      addr_d    = IDLE_ADDR;
      rw_d      = 1'b1;
    end

    // Write data spans HI plus one clk after M2 falls.
    doe_d  = !rw_q && ((state_d == ST_HI) || (state_q == ST_HI));
    done_d = hi_end && req_cyc_q;
    if (hi_end && req_cyc_q && rw_q) begin
      rdat_d = cpu_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_STOP;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      slot_we_q   <= 1'b0;
      slot_addr_q <= '0;
      slot_wdat_q <= '0;
      req_cyc_q   <= 1'b0;
      addr_q      <= IDLE_ADDR;
      rw_q        <= 1'b1;
      dout_q      <= '0;
      doe_q       <= 1'b0;
      done_q      <= 1'b0;
      rdat_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      slot_we_q   <= slot_we_d;
      slot_addr_q <= slot_addr_d;
      slot_wdat_q <= slot_wdat_d;
      req_cyc_q   <= req_cyc_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      dout_q      <= dout_d;
      doe_q       <= doe_d;
      done_q      <= done_d;
      rdat_q      <= rdat_d;
    end
  end

  assign req_ready = !pend_q;
  assign m2        = (state_q == ST_HI);
  assign cpu_addr  = addr_q;
  assign cpu_rw    = rw_q;
  assign cpu_dout  = dout_q;
  assign cpu_doe   = doe_q;
  assign done      = done_q;
  assign rd_data   = rdat_q;

endmodule

// File: tb/tb_cpu_bus_master.sv
// Directed bench for cpu_bus_master: writes, reads, back-to-back,
// accept-timing boundary, mid-cycle reset and run=0 stop.
module tb_cpu_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdat;
  logic        done;
  logic [7:0]  rd_data;
  logic        m2;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_dout;
  logic        cpu_doe;
  logic [7:0]  cpu_din;

  int total = 0;
  int bad   = 0;

  cpu_bus_master #(
    .PH_LO(6),
    .PH_HI(6),
    .IDLE_ADDR(16'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .run(run),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdat(req_wdat),
    .done(done),
    .rd_data(rd_data),
    .m2(m2),
    .cpu_addr(cpu_addr),
    .cpu_rw(cpu_rw),
    .cpu_dout(cpu_dout),
    .cpu_doe(cpu_doe),
    .cpu_din(cpu_din)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic we, input logic [15:0] a,
                      input logic [7:0] d);
    logic acc;
    acc = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdat  = d;
    for (int i = 0; i < 60 && !acc; i++) begin
      acc = req_ready;
      tick();
    end
    req_valid = 1'b0;
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL send_accept addr=%h never accepted", a);
    end
  endtask

  task automatic wait_addr(input logic [15:0] a);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (cpu_addr === a) hit = 1'b1;
      else tick();
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL wait_addr got=%h want=%h", cpu_addr, a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    run = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdat = '0;
    cpu_din = '0;
    tick();
    tick();
    total++;
    if ({m2, cpu_rw, cpu_addr, cpu_dout, cpu_doe, done, rd_data, req_ready}
        !== {1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1}) begin
      bad++;
      $display("FAIL reset m2=%b rw=%b addr=%h dout=%h doe=%b done=%b rd=%h rdy=%b",
               m2, cpu_rw, cpu_addr, cpu_dout, cpu_doe, done, rd_data,
               req_ready);
    end
    rst = 1'b0;
    run = 1'b1;
  endtask

  task automatic test_write();
    logic [2:0] got, exp;
    send(1'b1, 16'h8000, 8'h02);
    wait_addr(16'h8000);
    for (int k = 0; k <= 13; k++) begin
      got = {m2, cpu_doe, done};
      exp = {(k >= 6 && k < 12), (k >= 6 && k <= 12), (k == 12)};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL write_phase k=%0d m2/doe/done got=%b want=%b",
                 k, got, exp);
      end
      if (k < 12) begin
        total++;
        if (cpu_addr !== 16'h8000 || cpu_rw !== 1'b0) begin
          bad++;
          $display("FAIL write_addr k=%0d addr=%h rw=%b want 8000/0",
                   k, cpu_addr, cpu_rw);
        end
      end
      if (k >= 6 && k <= 12) begin
        total++;
        if (cpu_dout !== 8'h02) begin
          bad++;
          $display("FAIL write_dout k=%0d got=%h want=02", k, cpu_dout);
        end
      end
      if (k == 12) begin
        total++;
        if (cpu_addr !== 16'h0000 || cpu_rw !== 1'b1) begin
          bad++;
          $display("FAIL write_next addr=%h rw=%b want 0000/1",
                   cpu_addr, cpu_rw);
        end
      end
      if (k < 13) tick();
    end
  endtask

  task automatic test_read();
    send(1'b0, 16'h6010, 8'h00);
    wait_addr(16'h6010);
    for (int k = 0; k <= 12; k++) begin
      cpu_din = (k == 11) ? 8'hA5 : 8'h00;
      total++;
      if (cpu_doe !== 1'b0 || done !== (k == 12)) begin
        bad++;
        $display("FAIL read_phase k=%0d doe=%b done=%b", k, cpu_doe, done);
      end
      if (k == 12) begin
        total++;
        if (rd_data !== 8'hA5) begin
          bad++;
          $display("FAIL read_data got=%h want=a5", rd_data);
        end
      end
      if (k < 12) tick();
    end
    cpu_din = 8'h00;
  endtask

  task automatic test_back_to_back();
    int done_t[$];
    logic [7:0] done_d[$];
    logic [15:0] done_a[$];
    fork
      begin
        for (int i = 1; i <= 3; i++) begin
          send(1'b1, 16'h8000, 8'(i));
          total++;
          if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ready_low i=%0d got=%b want=0", i, req_ready);
          end
        end
      end
      begin
        logic [7:0] pd;
        logic [15:0] pa;
        pd = cpu_dout;
        pa = cpu_addr;
        for (int c = 0; c < 60; c++) begin
          tick();
          if (done) begin
            done_t.push_back(c);
            done_d.push_back(pd);
            done_a.push_back(pa);
          end
          pd = cpu_dout;
          pa = cpu_addr;
        end
      end
    join
    total++;
    if (done_t.size() != 3) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=3", done_t.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (done_d[i] !== 8'(i + 1) || done_a[i] !== 16'h8000) begin
          bad++;
          $display("FAIL b2b_data i=%0d addr=%h dout=%h want 8000/%0d",
                   i, done_a[i], done_d[i], i + 1);
        end
        if (i > 0) begin
          total++;
          if (done_t[i] - done_t[i-1] != 12) begin
            bad++;
            $display("FAIL b2b_gap i=%0d got=%0d want=12",
                     i, done_t[i] - done_t[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_boundary();
    int n;
    bit seen;
    for (int i = 0; i < 20 && m2 !== 1'b1; i++) tick();
    for (int i = 0; i < 20 && m2 !== 1'b0; i++) tick();
    total++;
    if (m2 !== 1'b0 || cpu_addr !== 16'h0000 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL bnd_start m2=%b addr=%h rdy=%b", m2, cpu_addr,
               req_ready);
    end
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'h8123;
    tick();
    req_valid = 1'b0;
    n = 1;
    seen = 1'b0;
    while (n < 30 && !seen) begin
      if (cpu_addr === 16'h8123) seen = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    total++;
    if (!seen || n != 12) begin
      bad++;
      $display("FAIL bnd_launch clk=%0d seen=%b want launch at 12", n, seen);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = done;
    end
  endtask

  task automatic test_reset_mid_write();
    int dn, de;
    send(1'b1, 16'h8055, 8'hAA);
    wait_addr(16'h8055);
    for (int k = 0; k < 8; k++) tick();
    total++;
    if (m2 !== 1'b1 || cpu_doe !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pre m2=%b doe=%b want 1/1", m2, cpu_doe);
    end
    rst = 1'b1;
    tick();
    total++;
    if ({m2, cpu_doe, cpu_rw, req_ready} !== 4'b0011) begin
      bad++;
      $display("FAIL rstmid_post m2=%b doe=%b rw=%b rdy=%b",
               m2, cpu_doe, cpu_rw, req_ready);
    end
    rst = 1'b0;
    dn = 0;
    de = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) dn++;
      if (cpu_doe) de++;
    end
    total++;
    if (dn != 0 || de != 0) begin
      bad++;
      $display("FAIL rstmid_drop done_cnt=%0d doe_cnt=%0d want 0/0", dn, de);
    end
  endtask

  task automatic test_run_stop();
    int errs;
    send(1'b1, 16'h8077, 8'h5C);
    wait_addr(16'h8077);
    run = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    total++;
    if ({done, m2, cpu_doe} !== 3'b101) begin
      bad++;
      $display("FAIL stop_done done=%b m2=%b doe=%b want 1/0/1",
               done, m2, cpu_doe);
    end
    send(1'b1, 16'h8099, 8'h33);
    total++;
    if (req_ready !== 1'b0) begin
      bad++;
      $display("FAIL stop_pending rdy=%b want 0", req_ready);
    end
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      if (m2 !== 1'b0 || cpu_rw !== 1'b1 || cpu_addr !== 16'h0000 ||
          req_ready !== 1'b0 || cpu_doe !== 1'b0) errs++;
      tick();
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL stop_hold bad_clks=%0d want 0", errs);
    end
    run = 1'b1;
    tick();
    total++;
    if (cpu_addr !== 16'h8099 || cpu_rw !== 1'b0 || m2 !== 1'b0) begin
      bad++;
      $display("FAIL stop_resume addr=%h rw=%b m2=%b want 8099/0/0",
               cpu_addr, cpu_rw, m2);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_boundary();
    test_reset_mid_write();
    test_run_stop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_bus_master.md
Name: cpu_bus_master

Overview:
- Initiator side of the NES CPU bus: generates M2, R/W, address and write data cycles toward a mapper.
- Used on the host side for mapper register writes, save-state register replay and bench stimulus.
- Converts a single-transaction valid/ready request into one M2-timed bus cycle.
- Free-runs dummy read cycles between transactions so M2 stays continuous.

Parameters:
- PH_LO, 6, clk cycles per M2 low phase (min 2)
- PH_HI, 6, clk cycles per M2 high phase (min 2)
- IDLE_ADDR, 16'h0000, address driven on dummy (idle) cycles

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- run  in  1  1 = generate bus cycles; 0 = stop M2 low after the current cycle
- req_valid  in  1  transaction request
- req_ready  out  1  request slot free
- req_we  in  1  1 = write, 0 = read
- req_addr  in  16  transaction address
- req_wdat  in  8  write data
- done  out  1  one-clk pulse when the requested cycle completes
- rd_data  out  8  read data, valid when done=1 on a read; held until the next done
- m2  out  1  CPU M2 phase clock
- cpu_addr  out  16  CPU address bus
- cpu_rw  out  1  1 = read, 0 = write
- cpu_dout  out  8  data driven on writes
- cpu_doe  out  1  data output enable
- cpu_din  in  8  bus data sampled on reads

Behaviour:
- Reset (synchronous, active high):
  - m2=0, cpu_rw=1, cpu_addr=IDLE_ADDR, cpu_dout=0, cpu_doe=0
  - done=0, rd_data=0, req_ready=1
  - Pending slot cleared; phase FSM to STOP.
  - Reset mid-transaction drops it: no done, no further write drive.
- FSM states STOP, LO, HI; phase counter wide enough for max(PH_LO, PH_HI).
  - STOP: m2=0. Enter LO when run=1.
  - LO: m2=0 for PH_LO clks, then HI.
  - HI: m2=1 for PH_HI clks. At the end, go to LO if run=1, else STOP.
- Cycle start is the first clk of LO. The cycle type is chosen there:
  - If the pending slot is full: cpu_addr=req_addr, cpu_rw=!req_we, cpu_dout=req_wdat. The cycle is marked as the requested one and the slot is freed.
  - Otherwise: dummy read, with cpu_addr=IDLE_ADDR and cpu_rw=1.
  - cpu_addr and cpu_rw are stable for the whole LO+HI cycle.
- Write data timing:
  - cpu_doe=1 from the first clk of HI through the first clk of the following LO or STOP (one clk hold after M2 falls).
  - cpu_doe=0 at all other times, including all read cycles.
- Read sampling: cpu_din is sampled on the last clk of HI.
- done:
  - Pulses on the clk after the last HI clk (the same clk M2 falls), only for requested cycles.
  - On a read, rd_data is updated on that same clk.
- Request handshake:
  - Accept on req_valid & req_ready; latch req_we, req_addr, req_wdat into the single pending slot.
  - req_ready=0 while the slot is full. It returns to 1 on the clk after the slot is consumed at cycle start.
  - A request accepted on the exact first-LO clk is not launched in that cycle; it launches at the next cycle start.
  - Accepting in any other clk of LO or HI also waits for the next cycle start.
- Back-to-back: at most one requested cycle per bus cycle. Period = PH_LO+PH_HI clks.
- run=0:
  - The current cycle finishes normally, including done and the doe hold.
  - Then m2 stays 0, cpu_rw=1, cpu_addr=IDLE_ADDR.
  - A pending request stays queued until run=1.
- No bus-conflict arbitration: cpu_doe is asserted only on writes, never on reads.

Test Plan:
1. Write: after rst, run=1; request we=1, addr=16'h8000, wdat=8'h02 →
   - cpu_addr=8000 and rw=0 from a cycle start
   - m2 rises 6 clk later; cpu_dout=02 with doe=1 for 7 clks
   - done pulses when m2 falls; rw=1 and addr=0000 on the next cycle.
2. Read: request we=0, addr=16'h6010, cpu_din=8'hA5 at the last HI clk (8'h00 elsewhere) → done=1 with rd_data=A5; doe stays 0 throughout.
3. Back-to-back: hold req_valid with writes 8000/01, 8000/02, 8000/03 →
   - three done pulses exactly 12 clks apart, with matching addr/dout
   - req_ready low while the slot is full
   - no dummy cycle between them.
4. Timing boundary: a request asserted on the first LO clk of a dummy cycle → that cycle stays IDLE_ADDR; the request launches on the next cycle start (12 clks later).
5. Reset mid-write: assert rst during the HI phase of a write → next clk m2=0, doe=0, rw=1, req_ready=1; no done ever appears for the dropped write.
6. run=0 during LO of a write →
   - the cycle completes with done
   - m2 then holds 0 for 20 clks
   - a request made meanwhile stays pending (req_ready=0) and launches on the first cycle after run=1.
